// File: rtl/ram_copy_engine.sv
// Copy engine driving a dual-port RAM: port 0 reads the source, port 1 writes the
// destination, one byte per cycle, direction chosen so overlapping regions copy safely.
module ram_copy_engine #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [ADDR_W:0]   len,
   output logic              busy,
   output logic              done,
   output logic              wr_en_0,
   output logic [ADDR_W-1:0] addr_0,
   input  logic [DATA_W-1:0] out_0,
   output logic              wr_en_1,
   output logic [ADDR_W-1:0] addr_1,
   output logic [DATA_W-1:0] in_1
);

   typedef enum logic [1:0] {IDLE, PRIME, STREAM, DONE} state_t;

   state_t            state;
   logic              descending;
   logic [ADDR_W:0]   last_idx;
   logic [ADDR_W:0]   wr_idx;
   logic [ADDR_W-1:0] dst_first;

   logic [ADDR_W:0]   len_m1;
   logic              start_desc;
   logic [ADDR_W-1:0] src_first_c;
   logic [ADDR_W-1:0] dst_first_c;
   logic [ADDR_W-1:0] rd_next;
   logic [ADDR_W-1:0] wr_next;

   // A descending copy starts at the top of both regions so overlapping bytes are read before overwritten.
   always_comb begin
      len_m1      = len - (ADDR_W+1)'(1);
      start_desc  = dst_addr > src_addr;
      src_first_c = start_desc ? src_addr + len_m1[ADDR_W-1:0] : src_addr;
      dst_first_c = start_desc ? dst_addr + len_m1[ADDR_W-1:0] : dst_addr;
      rd_next     = descending ? addr_0 - ADDR_W'(1) : addr_0 + ADDR_W'(1);
      wr_next     = descending ? addr_1 - ADDR_W'(1) : addr_1 + ADDR_W'(1);
   end

   assign wr_en_0 = 1'b0;
   assign in_1    = out_0;

   // The read address always runs one index ahead of the write address to cover the RAM read latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         wr_en_1    <= 1'b0;
         addr_0     <= '0;
         addr_1     <= '0;
         descending <= 1'b0;
         last_idx   <= '0;
         wr_idx     <= '0;
         dst_first  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  descending <= start_desc;
                  last_idx   <= len_m1;
                  dst_first  <= dst_first_c;
                  wr_idx     <= '0;
                  if (len == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state  <= PRIME;
                     busy   <= 1'b1;
                     addr_0 <= src_first_c;
                  end
               end
            end
            PRIME: begin
               state   <= STREAM;
               wr_en_1 <= 1'b1;
               addr_1  <= dst_first;
               wr_idx  <= '0;
               if (last_idx != '0) begin
                  addr_0 <= rd_next;
               end
            end
            STREAM: begin
               if (wr_idx == last_idx) begin
                  state   <= DONE;
                  wr_en_1 <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end else begin
                  wr_idx <= wr_idx + (ADDR_W+1)'(1);
                  addr_1 <= wr_next;
                  if (wr_idx + (ADDR_W+1)'(2) <= last_idx) begin
                     addr_0 <= rd_next;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_copy_engine.sv
// Scoreboard bench for ram_copy_engine: a behavioural RAM sits on both ports, and a
// memmove-style reference model predicts every write and the done cycle.
module tb_ram_copy_engine;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [11:0] src_addr = '0;
   logic [11:0] dst_addr = '0;
   logic [12:0] len = '0;
   logic        busy, done, wr_en_0, wr_en_1;
   logic [11:0] addr_0, addr_1;
   logic [7:0]  out_0, in_1;

   logic [7:0]  ram   [4096];
   logic [7:0]  model [4096];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   typedef struct {
      logic [11:0] addr;
      logic [7:0]  data;
   } wr_t;

   wr_t exp_wr[$];
   int  exp_done[$];

   ram_copy_engine #(.ADDR_W(12), .DATA_W(8)) dut (
      .clk(clk), .rst(rst), .start(start),
      .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
      .busy(busy), .done(done),
      .wr_en_0(wr_en_0), .addr_0(addr_0), .out_0(out_0),
      .wr_en_1(wr_en_1), .addr_1(addr_1), .in_1(in_1)
   );

   always #5 clk = ~clk;

   // Behavioural RAM: registered read on port 0, write on port 1, read sampled before the write.
   always @(posedge clk) begin
      cyc   <= cyc + 1;
      out_0 <= ram[addr_0];
      if (wr_en_1 === 1'b1) ram[addr_1] = in_1;
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every presented write or done pulse is matched against the scoreboard queues.
   always @(negedge clk) begin
      wr_t w;
      if (wr_en_1 === 1'b1) begin
         check_output("write_expected", exp_wr.size() > 0, 1);
         if (exp_wr.size() > 0) begin
            w = exp_wr.pop_front();
            check_output("write_addr", addr_1, w.addr);
            check_output("write_data", in_1, w.data);
         end
      end
      if (done === 1'b1) begin
         check_output("done_expected", exp_done.size() > 0, 1);
         if (exp_done.size() > 0) check_output("done_cycle", cyc, exp_done.pop_front());
      end
      if (!rst) check_output("wr_en_0_low", wr_en_0, 0);
   end

   task automatic apply_stimulus(input logic [11:0] s, input logic [11:0] d, input int n,
                                 input int rst_at, input bit poke);
      logic [7:0] snap[$];
      int         nwr, busy_cnt, t0;
      bit         desc, finished;
      @(negedge clk);
      desc = d > s;
      for (int j = 0; j < n; j++) snap.push_back(model[12'(s + j)]);
      nwr = (rst_at > 0 && rst_at - 1 < n) ? rst_at - 1 : n;
      for (int i = 0; i < nwr; i++) begin
         int  j;
         wr_t w;
         j = desc ? n - 1 - i : i;
         w.addr = 12'(d + j);
         w.data = snap[j];
         exp_wr.push_back(w);
         model[w.addr] = w.data;
      end
      t0 = cyc;
      if (rst_at == 0) exp_done.push_back(t0 + ((n == 0) ? 1 : n + 2));
      src_addr = s;
      dst_addr = d;
      len      = 13'(n);
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      busy_cnt = 0;
      finished = 0;
      for (int k = 1; k <= n + 20 && !finished; k++) begin
         if (k > 1) @(negedge clk);
         if (busy === 1'b1) busy_cnt++;
         if (poke && k == 3) begin
            start    = 1'b1;
            src_addr = ~s;
            dst_addr = s;
            len      = 13'd3;
         end else begin
            start = 1'b0;
         end
         if (rst_at > 0 && k == rst_at) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            finished = 1;
            check_output("rst_wr_en_1", wr_en_1, 0);
            check_output("rst_busy", busy, 0);
            check_output("rst_done", done, 0);
         end else if (done === 1'b1) begin
            finished = 1;
         end
      end
      start = 1'b0;
      check_output("copy_finished", finished, 1);
      if (rst_at == 0) check_output("busy_cycles", busy_cnt, (n == 0) ? 0 : n + 1);
      check_output("writes_drained", exp_wr.size(), 0);
   endtask

   task automatic preload(input logic [11:0] base, input logic [31:0] bytes4);
      for (int i = 0; i < 4; i++) begin
         ram[12'(base + i)]   = bytes4[31 - 8*i -: 8];
         model[12'(base + i)] = bytes4[31 - 8*i -: 8];
      end
   endtask

   initial begin
      int n, s, d, lo, hi, bad;
      for (int i = 0; i < 4096; i++) begin
         ram[i]   = 8'($urandom);
         model[i] = ram[i];
      end
      rst   = 1'b1;
      start = 1'b1;
      repeat (2) @(negedge clk);
      check_output("reset_busy", busy, 0);
      check_output("reset_done", done, 0);
      check_output("reset_wr_en_1", wr_en_1, 0);
      check_output("reset_addr_0", addr_0, 0);
      check_output("reset_addr_1", addr_1, 0);
      check_output("reset_wr_en_0", wr_en_0, 0);
      rst   = 1'b0;
      start = 1'b0;

      preload(12'h010, 32'hA1B2C3D4);
      apply_stimulus(12'h010, 12'h100, 4, 0, 0);
      check_output("asc_dst_0", ram[12'h100], 8'hA1);
      check_output("asc_dst_3", ram[12'h103], 8'hD4);
      check_output("asc_src_0", ram[12'h010], 8'hA1);

      preload(12'h020, 32'h01020304);
      apply_stimulus(12'h020, 12'h021, 4, 0, 0);
      check_output("ovl_dst_021", ram[12'h021], 8'h01);
      check_output("ovl_dst_024", ram[12'h024], 8'h04);

      preload(12'hFFE, 32'h11223344);
      apply_stimulus(12'hFFE, 12'h200, 4, 0, 0);
      check_output("wrap_dst_2", ram[12'h202], 8'h33);
      check_output("wrap_dst_3", ram[12'h203], 8'h44);

      apply_stimulus(12'h300, 12'h400, 0, 0, 0);
      apply_stimulus(12'h040, 12'h500, 8, 0, 1);
      apply_stimulus(12'h060, 12'h600, 16, 5, 0);
      repeat (4) @(negedge clk);
      apply_stimulus(12'h000, 12'h000, 4096, 0, 0);

      for (int r = 0; r < 10; r++) begin
         n = $urandom_range(1, 40);
         s = $urandom_range(0, 4095 - n);
         if ($urandom_range(0, 1) == 1) begin
            lo = (s - n < 0) ? 0 : s - n;
            hi = (s + n > 4095 - n) ? 4095 - n : s + n;
            d  = $urandom_range(lo, hi);
         end else begin
            d = $urandom_range(0, 4095 - n);
         end
         apply_stimulus(12'(s), 12'(d), n, 0, 0);
      end

      repeat (4) @(negedge clk);
      check_output("final_writes_empty", exp_wr.size(), 0);
      check_output("final_done_empty", exp_done.size(), 0);
      bad = 0;
      for (int i = 0; i < 4096; i++) if (ram[i] !== model[i]) bad++;
      check_output("memory_image", bad, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
